// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if: word-memory bus between the copy engine (master) and the memory (slave)
interface mem_copy_engine_if #(parameter int ADDR_W = 6, parameter int DATA_W = 32);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd;
  logic              memwrite;
  logic              memread;
  modport master (output addr, wd, memwrite, memread, input rd);
  modport slave (input addr, wd, memwrite, memread, output rd);
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies len words from src to dst one read/write pair at a time, ascending, with address wrap
module mem_copy_engine #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      src,
  input  logic [ADDR_W-1:0]      dst,
  input  logic [ADDR_W:0]        len,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W:0]        count,
  mem_copy_engine_if.master      mem
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d, count_q, count_d, count_inc, len_clamp;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              accept;
  always_comb begin
    accept    = state_q == IDLE && start;
    count_inc = count_q + 1'b1;
    len_clamp = len[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : len;
    state_d   = state_q == IDLE  ? (start ? (len == '0 ? DONE : READ) : IDLE) :
                state_q == READ  ? WRITE :
                state_q == WRITE ? (count_inc == len_q ? DONE : READ) : IDLE;
    src_d     = accept ? src : src_q;
    dst_d     = accept ? dst : dst_q;
    len_d     = accept ? len_clamp : len_q;
    count_d   = accept ? '0 : state_q == WRITE ? count_inc : count_q;
    buf_d     = state_q == READ ? mem.rd : buf_q;
    busy      = state_q == READ || state_q == WRITE;
    done      = state_q == DONE;
    count     = count_q;
    mem.memread  = state_q == READ;
    mem.memwrite = state_q == WRITE;
    mem.addr  = state_q == READ  ? src_q + count_q[ADDR_W-1:0] :
                state_q == WRITE ? dst_q + count_q[ADDR_W-1:0] : '0;
    mem.wd    = state_q == WRITE ? buf_q : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      count_q <= count_d;
      buf_q   <= buf_d;
    end
  end
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed copies checked every cycle against a transaction-level copy model
module tb_mem_copy_engine;
  localparam int K_IDLE = 0, K_RD = 1, K_WR = 2, K_DONE = 3;
  typedef struct {
    int         kind;
    logic [5:0] addr;
    logic [6:0] cnt;
  } ent_t;
  logic        clk = 0, rst = 0, start = 0;
  logic [5:0]  src = 0, dst = 0;
  logic [6:0]  len = 0;
  logic        busy, done;
  logic [6:0]  count;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  ent_t        q[$];
  ent_t        e = '{K_IDLE, 6'd0, 7'd0};
  logic [31:0] mbuf = 0;
  logic [23:0] rd_trace = 0;
  int          total = 0, bad = 0, done_cnt = 0;
  mem_copy_engine_if #(.ADDR_W(6), .DATA_W(32)) bus();
  mem_copy_engine #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .count(count), .mem(bus)
  );
  always #5 clk = ~clk;
  assign bus.rd = bus.memread ? mem[bus.addr] : 32'hdeadbeef;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = i;
    forever begin
      @(posedge clk);
      if (bus.memwrite) mem[bus.addr] = bus.wd;
    end
  end
  initial begin : model
    int n;
    for (int i = 0; i < 64; i++) ref_mem[i] = i;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        e = '{K_IDLE, 6'd0, 7'd0};
        mbuf = 0;
      end else begin
        if (e.kind == K_RD) mbuf = ref_mem[e.addr];
        if (e.kind == K_WR) ref_mem[e.addr] = mbuf;
        if (e.kind == K_IDLE && start) begin
          n = len > 7'd64 ? 64 : int'(len);
          for (int i = 0; i < n; i++) begin
            q.push_back('{K_RD, 6'(src + i), 7'(i)});
            q.push_back('{K_WR, 6'(dst + i), 7'(i)});
          end
          q.push_back('{K_DONE, 6'd0, 7'(n)});
        end
        if (q.size() > 0) e = q.pop_front();
        else e = '{K_IDLE, 6'd0, e.cnt};
      end
    end
  end
  initial forever begin
    @(negedge clk);
    chk("rw_excl", bus.memread & bus.memwrite, 0);
    chk("outputs", {busy, done, bus.memread, bus.memwrite, bus.addr, count},
        {e.kind == K_RD || e.kind == K_WR, e.kind == K_DONE, e.kind == K_RD, e.kind == K_WR,
         (e.kind == K_RD || e.kind == K_WR) ? e.addr : 6'd0, e.cnt});
    chk("wd", bus.wd, e.kind == K_WR ? mbuf : 32'd0);
    if (done) done_cnt++;
    if (bus.memread) rd_trace = {rd_trace[17:0], bus.addr};
  end
  task automatic go(input logic [5:0] s, input logic [5:0] d, input logic [6:0] l, input int lat, input bit pulse);
    int cyc;
    @(negedge clk);
    start = 1; src = s; dst = d; len = l;
    @(negedge clk);
    start = 0; src = ~s; dst = ~d; len = 7'd5;
    cyc = 1;
    while (!done && cyc < 300) begin
      start = pulse && cyc == 3;
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, lat);
    start = 0;
    @(negedge clk);
  endtask
  task automatic img();
    int errs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) errs++;
    chk("mem_image", errs, 0);
  endtask
  initial begin
    #1;
    chk("reset_out", {busy, done, bus.memread, bus.memwrite, bus.addr, bus.wd, count}, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    go(6'd4, 6'd40, 7'd3, 7, 0);
    chk("t1_m40", mem[40], 4);
    chk("t1_m41", mem[41], 5);
    chk("t1_m42", mem[42], 6);
    chk("t1_count", count, 3);
    img();
    go(6'd62, 6'd10, 7'd4, 9, 0);
    chk("t2_m10_13", {mem[10][7:0], mem[11][7:0], mem[12][7:0], mem[13][7:0]}, 32'h3e3f0001);
    chk("read_addrs", rd_trace, {6'd62, 6'd63, 6'd0, 6'd1});
    img();
    go(6'd7, 6'd9, 7'd0, 1, 0);
    chk("t3_count", count, 0);
    chk("t3_m9", mem[9], 9);
    img();
    @(negedge clk);
    start = 1; src = 0; dst = 32; len = 8;
    @(negedge clk);
    start = 0;
    repeat (4) @(posedge clk);
    #2 rst = 0;
    #1 chk("async_reset", {busy, done, bus.memread, bus.memwrite, bus.addr, bus.wd, count}, 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    chk("rst_m32", mem[32], 0);
    chk("rst_m33", mem[33], 1);
    chk("rst_m34", mem[34], 34);
    chk("rst_m39", mem[39], 39);
    img();
    go(6'd50, 6'd20, 7'd1, 3, 0);
    chk("t7_m20", mem[20], 50);
    img();
    go(6'd0, 6'd1, 7'd3, 7, 1);
    chk("t4_m1_3", {mem[1], mem[2], mem[3]}, 0);
    chk("t4_count", count, 3);
    img();
    go(6'd5, 6'd5, 7'd100, 129, 0);
    chk("t5_count", count, 64);
    img();
    chk("done_pulses", done_cnt, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
